// File: rtl/wb_mem_bridge_if.sv
// CPU load/store port and Wishbone classic master signals of wb_mem_bridge.
// The master modport is the bridge's view; slave is the CPU/memory side.
interface wb_mem_bridge_if;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_wdata_i;
    logic        cpu_ready_o;
    logic        cpu_done_o;
    logic        cpu_err_o;
    logic [31:0] cpu_rdata_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_addr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;

    modport master (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_wdata_i, wb_data_i, wb_ack_i,
        output cpu_ready_o, cpu_done_o, cpu_err_o, cpu_rdata_o,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_data_o
    );

    modport slave (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_wdata_i, wb_data_i, wb_ack_i,
        input  cpu_ready_o, cpu_done_o, cpu_err_o, cpu_rdata_o,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_data_o
    );
endinterface

// File: rtl/wb_mem_bridge.sv
// One Wishbone classic cycle per CPU request, with a forced cyc/stb-low gap after each ack.
// Define WB_MEM_BRIDGE_TIMEOUT_EN to abort cycles that see no ack within TIMEOUT_CYCLES.
module wb_mem_bridge #(
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    wb_mem_bridge_if.master  bus
);
    typedef enum logic [1:0] {IDLE, BUS, GAP} state_t;

    state_t      state_q;
    logic        cyc_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  sel_q;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic        done_q;
    logic [31:0] rdata_q;
    logic [3:0]  gap_q;

`ifdef WB_MEM_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_q, to_d;
    logic          to_hit;
    logic          err_q;

    // Saturating count of BUS cycles; the limit is hit on the edge it would reach TIMEOUT_CYCLES.
    always_comb begin
        to_d   = (to_q == TW'(TIMEOUT_CYCLES)) ? to_q : to_q + TW'(1);
        to_hit = (to_d == TW'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            to_q <= '0;
        else if (state_q == IDLE && bus.cpu_req_i)
            to_q <= '0;
        else if (state_q == BUS)
            to_q <= to_d;
    end

    assign bus.cpu_err_o = err_q;
`else
    assign bus.cpu_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            rdata_q <= '0;
            gap_q   <= '0;
`ifdef WB_MEM_BRIDGE_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef WB_MEM_BRIDGE_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req_i) begin
                        we_q    <= bus.cpu_we_i;
                        addr_q  <= bus.cpu_addr_i;
                        sel_q   <= bus.cpu_sel_i;
                        wdata_q <= bus.cpu_wdata_i;
                        cyc_q   <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    if (bus.wb_ack_i) begin
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        if (!we_q)
                            rdata_q <= bus.wb_data_i;
                        gap_q   <= '0;
                        state_q <= GAP;
                    end
`ifdef WB_MEM_BRIDGE_TIMEOUT_EN
                    else if (to_hit) begin
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        gap_q   <= '0;
                        state_q <= GAP;
                    end
`endif
                end
                GAP: begin
                    // The slave only starts on a rising stb&cyc, so it must see low cycles here.
                    if (gap_q == 4'(GAP_CYCLES - 1)) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cpu_ready_o = ready_q;
    assign bus.cpu_done_o  = done_q;
    assign bus.cpu_rdata_o = rdata_q;
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = cyc_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_addr_o   = addr_q;
    assign bus.wb_sel_o    = sel_q;
    assign bus.wb_data_o   = wdata_q;
endmodule

// File: tb/tb_wb_mem_bridge.sv
// Directed bench for wb_mem_bridge: reference model plus per-cycle compare and literal checks.
// Timeout cases run only when WB_MEM_BRIDGE_TIMEOUT_EN is defined.
module tb_wb_mem_bridge;
    localparam int GAP    = 1;
    localparam int TO_CYC = 64;
`ifdef WB_MEM_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_mem_bridge_if bus();

    wb_mem_bridge #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what each output must be after every edge.
    logic        m_ready, m_cyc, m_we, m_done, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_sel;
    int          m_gap, m_age;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b1; m_cyc <= 1'b0; m_we <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_sel <= '0; m_gap <= 0; m_age <= 0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (m_cyc) begin
                if (bus.wb_ack_i) begin
                    m_cyc <= 1'b0; m_done <= 1'b1; m_gap <= GAP;
                    if (!m_we) m_rdata <= bus.wb_data_i;
                end else if (TO_EN && m_age + 1 >= TO_CYC) begin
                    m_cyc <= 1'b0; m_done <= 1'b1; m_err <= 1'b1; m_rdata <= '0; m_gap <= GAP;
                end else begin
                    m_age <= m_age + 1;
                end
            end else if (m_gap > 0) begin
                m_gap <= m_gap - 1;
                if (m_gap == 1) m_ready <= 1'b1;
            end else if (bus.cpu_req_i) begin
                m_we <= bus.cpu_we_i; m_addr <= bus.cpu_addr_i; m_sel <= bus.cpu_sel_i;
                m_wdata <= bus.cpu_wdata_i; m_cyc <= 1'b1; m_ready <= 1'b0; m_age <= 0;
            end
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(bus.cpu_ready_o), 32'(m_ready));
            chk("done",  32'(bus.cpu_done_o),  32'(m_done));
            chk("err",   32'(bus.cpu_err_o),   32'(m_err));
            chk("rdata", bus.cpu_rdata_o, m_rdata);
            chk("cyc",   32'(bus.wb_cyc_o), 32'(m_cyc));
            chk("stb",   32'(bus.wb_stb_o), 32'(m_cyc));
            chk("we",    32'(bus.wb_we_o),  32'(m_we));
            chk("addr",  bus.wb_addr_o, m_addr);
            chk("sel",   32'(bus.wb_sel_o), 32'(m_sel));
            chk("wdata", bus.wb_data_o, m_wdata);
        end
    end

    // Monitor: stb rising edges and done pulses.
    int   stb_rises = 0, done_cnt = 0;
    logic prev_stb = 1'b0;
    always @(negedge clk) begin
        if (bus.wb_stb_o && !prev_stb) stb_rises++;
        if (bus.cpu_done_o) done_cnt++;
        prev_stb = bus.wb_stb_o;
    end

    // Slave: acks ack_lat cycles after stb is seen, or fires one stray ack on request.
    bit          ack_en = 1'b1;
    int          ack_lat = 0;
    logic [31:0] slv_rdata = '0;
    int          stray_req = 0, stray_done = 0;
    initial begin
        int cnt;
        cnt = 0;
        bus.wb_ack_i  = 1'b0;
        bus.wb_data_i = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.wb_ack_i) begin
                bus.wb_ack_i = 1'b0;
                cnt = 0;
            end else if (stray_req != stray_done) begin
                bus.wb_ack_i  = 1'b1;
                bus.wb_data_i = 32'h5757_5757;
                stray_done++;
            end else if (ack_en && bus.wb_stb_o) begin
                if (cnt == ack_lat) begin
                    bus.wb_ack_i  = 1'b1;
                    bus.wb_data_i = slv_rdata;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
        logic r;
        bit   acc;
        acc = 1'b0;
        bus.cpu_we_i = we; bus.cpu_addr_i = a; bus.cpu_sel_i = s; bus.cpu_wdata_i = d;
        bus.cpu_req_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            r = bus.cpu_ready_o;
            @(posedge clk);
            #1;
            if (r) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("accept_wait", 32'd0, 32'd1);
        // Inputs are only sampled on the accept edge; scramble them afterwards.
        bus.cpu_req_i = 1'b0;
        bus.cpu_we_i = ~we; bus.cpu_addr_i = ~a; bus.cpu_sel_i = ~s; bus.cpu_wdata_i = ~d;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!bus.cpu_done_o && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (!bus.cpu_done_o) chk("done_wait", 32'd0, 32'd1);
    endtask

    task automatic wait_ready();
        int i;
        i = 0;
        while (!bus.cpu_ready_o && i < 50) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (!bus.cpu_ready_o) chk("ready_wait", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        int c, r0, d0;
        bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0;
        bus.cpu_sel_i = '0; bus.cpu_wdata_i = '0;

        // Reset state
        #12;
        chk("rst_ready", 32'(bus.cpu_ready_o), 32'd1);
        chk("rst_cyc",   32'(bus.wb_cyc_o), 32'd0);
        chk("rst_stb",   32'(bus.wb_stb_o), 32'd0);
        chk("rst_done",  32'(bus.cpu_done_o), 32'd0);
        chk("rst_err",   32'(bus.cpu_err_o), 32'd0);
        chk("rst_rdata", bus.cpu_rdata_o, 32'd0);
        chk("rst_addr",  bus.wb_addr_o, 32'd0);
        chk("rst_wbus",  {bus.wb_data_o[27:0], bus.wb_sel_o}, 32'd0);
        chk_en = 1'b1;
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single SSRAM read, ack 3 cycles after stb rises
        ack_lat = 3; slv_rdata = 32'hDEAD_BEEF;
        issue(1'b0, 32'h0000_0010, 4'hF, 32'h0);
        chk("rd_stb", 32'(bus.wb_stb_o & bus.wb_cyc_o), 32'd1);
        wait_done(c);
        chk("rd_latency", 32'(c), 32'd4);
        chk("rd_data", bus.cpu_rdata_o, 32'hDEAD_BEEF);
        chk("rd_err", 32'(bus.cpu_err_o), 32'd0);
        chk("rd_gap_cyc", 32'(bus.wb_cyc_o | bus.cpu_ready_o), 32'd0);
        @(posedge clk); #1;
        chk("rd_ready_after_gap", 32'(bus.cpu_ready_o), 32'd1);
        chk("rd_done_pulse", 32'(bus.cpu_done_o), 32'd0);

        // Byte write: bus fields held while waiting for ack
        ack_lat = 2; slv_rdata = 32'h1111_2222;
        issue(1'b1, 32'h0000_0104, 4'h2, 32'h0000_AB00);
        chk("wr_we", 32'(bus.wb_we_o), 32'd1);
        chk("wr_sel", 32'(bus.wb_sel_o), 32'h2);
        chk("wr_data", bus.wb_data_o, 32'h0000_AB00);
        @(posedge clk); #1;
        chk("wr_addr_held", bus.wb_addr_o, 32'h0000_0104);
        chk("wr_data_held", bus.wb_data_o, 32'h0000_AB00);
        wait_done(c);
        chk("wr_rdata_kept", bus.cpu_rdata_o, 32'hDEAD_BEEF);
        chk("wr_err", 32'(bus.cpu_err_o), 32'd0);
        wait_ready();

        // Back-to-back: request held high, three separate stb rising edges
        ack_lat = 1; slv_rdata = 32'h1234_5678;
        r0 = stb_rises; d0 = done_cnt; c = 0;
        bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h20; bus.cpu_sel_i = 4'hF;
        bus.cpu_req_i = 1'b1;
        for (int i = 0; i < 100 && c < 3; i++) begin
            @(posedge clk); #1;
            if (bus.cpu_done_o) c++;
        end
        bus.cpu_req_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_stb_rises", 32'(stb_rises - r0), 32'd3);
        chk("b2b_dones", 32'(done_cnt - d0), 32'd3);
        chk("b2b_rdata", bus.cpu_rdata_o, 32'h1234_5678);

        // Flash latency: ack on the 34th bus cycle
        ack_lat = 33; slv_rdata = 32'hF1A5_0001;
        issue(1'b0, 32'h0800_0000, 4'hF, 32'h0);
        chk("fl_addr", bus.wb_addr_o, 32'h0800_0000);
        wait_done(c);
        chk("fl_latency", 32'(c), 32'd34);
        chk("fl_err", 32'(bus.cpu_err_o), 32'd0);
        chk("fl_data", bus.cpu_rdata_o, 32'hF1A5_0001);
        wait_ready();

        // Stray ack in IDLE is ignored
        d0 = done_cnt;
        stray_req++;
        repeat (3) @(posedge clk);
        #1;
        chk("stray_idle_done", 32'(done_cnt - d0), 32'd0);
        chk("stray_idle_ready", 32'(bus.cpu_ready_o), 32'd1);
        chk("stray_idle_rdata", bus.cpu_rdata_o, 32'hF1A5_0001);

`ifdef WB_MEM_BRIDGE_TIMEOUT_EN
        // No ack: abort after TO_CYC bus cycles
        ack_en = 1'b0;
        issue(1'b0, 32'h0000_0040, 4'hF, 32'h0);
        wait_done(c);
        chk("to_latency", 32'(c), 32'(TO_CYC));
        chk("to_err", 32'(bus.cpu_err_o), 32'd1);
        chk("to_rdata", bus.cpu_rdata_o, 32'h0);
        chk("to_cyc", 32'(bus.wb_cyc_o), 32'd0);
        stray_req++;
        @(posedge clk); #1;
        chk("to_stray_gap_ready", 32'(bus.cpu_ready_o), 32'd1);
        chk("to_stray_gap_done", 32'(bus.cpu_done_o), 32'd0);
        ack_en = 1'b1;
        // Ack on the limit cycle wins
        ack_lat = TO_CYC - 1; slv_rdata = 32'h0000_600D;
        issue(1'b0, 32'h0000_0044, 4'hF, 32'h0);
        wait_done(c);
        chk("to_ack_latency", 32'(c), 32'(TO_CYC));
        chk("to_ack_err", 32'(bus.cpu_err_o), 32'd0);
        chk("to_ack_data", bus.cpu_rdata_o, 32'h0000_600D);
        wait_ready();
`endif

        // Reset in the middle of a bus cycle
        ack_en = 1'b0;
        issue(1'b0, 32'h0000_0080, 4'hF, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
        chk("mid_rst_stb", 32'(bus.wb_stb_o), 32'd0);
        chk("mid_rst_ready", 32'(bus.cpu_ready_o), 32'd1);
        chk("mid_rst_done", 32'(bus.cpu_done_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(bus.cpu_ready_o), 32'd1);
        chk("post_rst_no_done", 32'(done_cnt - d0), 32'd0);

        // Recovery: zero-latency ack
        ack_lat = 0; slv_rdata = 32'hCAFE_F00D;
        issue(1'b0, 32'h0000_00C0, 4'hF, 32'h0);
        wait_done(c);
        chk("rec_latency", 32'(c), 32'd1);
        chk("rec_data", bus.cpu_rdata_o, 32'hCAFE_F00D);
        wait_ready();
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_mem_bridge.md
Name: wb_mem_bridge

Overview:
- Wishbone master sequencer between the CPU load/store port and the SSRAM/flash memory controller.
- Accepts one CPU request with a ready/valid handshake and runs exactly one Wishbone classic cycle per request.
- Drops stb/cyc for a programmable gap after every ack, because the memory controller only starts a new access on a rising edge of stb&cyc.
- Returns read data plus a done/error pulse to the CPU.

Parameters:
- GAP_CYCLES, 1: idle cycles with cyc/stb low after each completed cycle; legal range 1..15.
- TIMEOUT_CYCLES, 64: BUS-state cycles allowed before abort; must exceed the flash ack latency of ~34 cycles; legal range 2..1023.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- cpu_req_i  in  1  request valid
- cpu_we_i  in  1  1 = write
- cpu_addr_i  in  32  byte address; bit 27 selects flash
- cpu_sel_i  in  4  byte lanes
- cpu_wdata_i  in  32  write data
- cpu_ready_o  out  1  bridge can accept a request this cycle
- cpu_done_o  out  1  one-cycle completion pulse
- cpu_err_o  out  1  qualifies cpu_done_o: access aborted
- cpu_rdata_o  out  32  read data, valid with cpu_done_o
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_addr_o  out  32  Wishbone address
- wb_sel_o  out  4  Wishbone byte select
- wb_data_o  out  32  Wishbone write data
- wb_data_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset: clock is clk_i; reset rst_n_i is asynchronous and active-low. All outputs are registered. Reset values:
  - cyc/stb/we = 0
  - addr/sel/data = 0
  - cpu_done_o = 0, cpu_err_o = 0, cpu_rdata_o = 0
  - cpu_ready_o = 1
  - state = IDLE, counters = 0
- State IDLE:
  - cpu_ready_o = 1.
  - On cpu_req_i at edge N, latch we/addr/sel/wdata into wb_*_o.
  - Assert cyc=stb=1 from cycle N+1; go to BUS; cpu_ready_o = 0 from N+1.
- State BUS:
  - Hold all wb_*_o stable. Increment the timeout counter each cycle.
  - On wb_ack_i at edge M:
    - Clear cyc/stb at M+1.
    - If read, capture wb_data_i into cpu_rdata_o; if write, cpu_rdata_o is unchanged.
    - Pulse cpu_done_o at M+1 with cpu_err_o = 0.
    - Go to GAP.
  - Minimum request-to-done latency is 2 cycles plus the slave ack latency.
- State GAP:
  - cyc/stb = 0, cpu_ready_o = 0.
  - Count GAP_CYCLES cycles, then go to IDLE; cpu_ready_o = 1 in the first IDLE cycle.
  - Back-to-back requests therefore always produce a stb&cyc rising edge at the slave.
- Error/done registers:
  - cpu_done_o and cpu_err_o are high for exactly one cycle.
  - cpu_err_o is 0 whenever cpu_done_o is 0.
- Stray acks: wb_ack_i outside BUS is ignored, with no state or output change.
- Request input: cpu_req_i while cpu_ready_o = 0 is ignored; the CPU holds it until accepted. Request inputs are sampled only on the accept edge.
- Timeout counter: width is ceil(log2(TIMEOUT_CYCLES+1)). It clears on entry to BUS and saturates, never wrapping.
- Reset mid-operation: reset asserted in BUS or GAP forces all outputs to reset values immediately. No done pulse is issued for the aborted access.
- wb_addr_o carries the full cpu_addr_i; flash/SSRAM decode belongs to the slave.

Optional Feature:
- Macro: WB_MEM_BRIDGE_TIMEOUT_EN.
- Defined:
  - If the BUS counter reaches TIMEOUT_CYCLES with no ack, drop cyc/stb next cycle.
  - Pulse cpu_done_o with cpu_err_o = 1 and cpu_rdata_o = 32'h0, then go to GAP.
  - If ack arrives in the same cycle the limit is reached, the ack wins (normal completion, err = 0).
- Undefined:
  - No counter is synthesised; BUS waits indefinitely for ack.
  - cpu_err_o is tied to 0.

Test Plan:
- Single SSRAM read:
  - Stimulus: addr 0x0000_0010, sel 0xF, slave acks 3 cycles after stb rises with data 0xDEAD_BEEF.
  - Required: cpu_done_o one cycle after ack, cpu_rdata_o = 0xDEAD_BEEF, err = 0, cyc/stb low for exactly GAP_CYCLES = 1 before ready.
- Byte write:
  - Stimulus: addr 0x0000_0104, sel 0x2, wdata 0x0000_AB00.
  - Required: wb_we_o = 1, wb_sel_o = 0x2, wb_data_o = 0x0000_AB00 held stable until ack; cpu_rdata_o unchanged.
- Back-to-back:
  - Stimulus: cpu_req_i held high for 3 requests, slave acks 1 cycle after stb.
  - Required: 3 separate stb rising edges, each separated by ≥1 low cycle; 3 done pulses.
- Flash latency:
  - Stimulus: addr 0x0800_0000, ack after 34 cycles, TIMEOUT_CYCLES = 64.
  - Required: normal completion, err = 0.
- Timeout, macro defined:
  - Stimulus: TIMEOUT_CYCLES = 8, no ack.
  - Required: done with err = 1 and rdata = 0 at cycle 9 after stb rise; a stray ack in GAP is ignored.
  - Also: ack on the 8th cycle gives err = 0.
- Reset mid-cycle:
  - Stimulus: deassert rst_n_i in BUS.
  - Required: cyc/stb = 0 asynchronously, no done pulse, ready = 1 after release.
